pcm_frame_buffer: RTL and testbench
===================================

PCM_FRAME_BUFFER -- requirements
Module: pcm_frame_buffer

Interface
REQ-001 Parameter NCH, default 4: number of microphone channels per frame, 1..16.
REQ-002 Parameter W, default 16: PCM sample width, signed two's complement.
REQ-003 Parameter DEPTH, default 8: FIFO capacity in frames; a power of 2, at least 2.
REQ-004 Parameter HDR, default 1: 1 emits a header word before each frame; 0 emits data words only.
REQ-005 Port CLKDIVF0, input, 1 bit: the output-sample clock, rising edge.
REQ-006 Port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port in_stb, input, 1 bit: one-cycle strobe marking that x_in holds a new frame.
REQ-008 Port x_in, input, NCH*W bits: channel c occupies x_in[c*W +: W].
REQ-009 Port m_data, output, W bits: the stream word (header or sample).
REQ-010 Port m_valid, output, 1 bit: m_data is valid.
REQ-011 Port m_ready, input, 1 bit: the consumer accepts the word.
REQ-012 Port m_hdr, output, 1 bit: the current word is a header.
REQ-013 Port m_last, output, 1 bit: the current word is the last word of its frame (channel NCH-1).
REQ-014 Port m_chan, output, $clog2(NCH) bits (minimum 1): channel index of the current data word; 0 during a header.
REQ-015 Port overflow, output, 1 bit: sticky flag, set when any frame is dropped.
REQ-016 Port clr_ovf, input, 1 bit: synchronous clear for overflow.
REQ-017 Port level, output, $clog2(DEPTH)+1 bits: number of stored frames.

Function
REQ-018 When in_stb=1 and level<DEPTH, all NCH samples of x_in shall be written as one frame, together with the current sequence number.
REQ-019 When in_stb=1 and level==DEPTH, the whole frame shall be dropped (no partial frame is ever stored) and overflow shall be set on the next edge.
REQ-020 The sequence counter shall be W bits wide, start at 0, and increment on every in_stb, accepted or dropped. It wraps from 2^W-1 to 0, so a gap in the sequence reveals dropped frames.
REQ-021 The output FSM shall have three states: IDLE, HEAD, DATA.
- IDLE moves to HEAD (HDR=1) or DATA (HDR=0) when level>0.
- HEAD moves to DATA on a handshake.
- DATA holds while the channel index is below NCH-1.
- On the last handshake in DATA, the FSM moves to HEAD/DATA if another frame is stored, otherwise to IDLE.
REQ-022 A handshake shall be m_valid and m_ready both high on a rising edge. m_valid=1 exactly in HEAD and DATA.
REQ-023 While m_valid=1 and m_ready=0, m_data, m_hdr, m_last and m_chan shall hold stable.
REQ-024 m_data shall carry the sequence number in HEAD and sample m_chan of the head frame in DATA. m_hdr=1 only in HEAD; m_last=1 only in DATA with m_chan==NCH-1.
REQ-025 The frame shall be popped (level decrements) on the m_last handshake.
REQ-026 A push and a pop in the same cycle shall leave level unchanged. This also holds at level==DEPTH: the push is accepted and no overflow is raised.
REQ-027 Latency: a frame written at edge k into an empty buffer shall raise m_valid after edge k+1. A frame is never presented in the cycle it is written.
REQ-028 Back-to-back stored frames shall stream with no idle cycle between them when m_ready is held at 1.
REQ-029 When clr_ovf and a drop coincide, overflow shall remain 1 (set wins).
REQ-030 in_stb shall be ignored while RST=1. Read and write pointers shall wrap modulo DEPTH.

Reset
REQ-031 On RST=1, the block shall immediately drive the following values, independent of the clock:
- FSM in IDLE, m_valid=0, m_hdr=0, m_last=0, m_chan=0, m_data=0;
- level=0, overflow=0, sequence counter=0, pointers=0.
REQ-032 A reset mid-frame shall discard all stored and partially streamed frames; the consumer sees m_valid fall with no m_last.
REQ-033 Frame memory contents need not be reset.

Structure
REQ-034 Package pcm_frame_pkg shall hold the state enum (IDLE, HEAD, DATA) and the default values of NCH, W, DEPTH and HDR.
REQ-035 Frame storage shall be a sub-module pcm_frame_ram: DEPTH x (NCH*W+W) bits, one write port, registered-address read port. All control logic stays in pcm_frame_buffer.

Verification
REQ-036 Single frame: NCH=4, HDR=1, one in_stb with samples {1,-2,3,-4}, m_ready=1 → the stream is 0(hdr), 1, -2, 3, -4, with m_last on -4; m_valid is first high the cycle after the write; level returns to 0.
REQ-037 Backpressure: m_ready toggling 1,0,0,1 → each word is held stable while m_ready=0; no word is lost or duplicated.
REQ-038 Overflow: DEPTH=8, m_ready=0, 10 strobes → level=8 and overflow=1. After m_ready=1 the headers read 0..7; the next accepted frame's header is 10. clr_ovf then clears overflow.
REQ-039 Full push+pop: level=8, an in_stb coincident with the m_last handshake → level stays 8 and overflow stays 0.
REQ-040 Reset mid-DATA (m_chan=2): RST pulse → m_valid=0 and level=0 immediately; the next frame's header is 0.
REQ-041 HDR=0, NCH=1, in_stb every cycle, m_ready=1 → one word per cycle, each with m_last=1; no drops and overflow=0.

Source files
------------

// File: rtl/pcm_frame_pkg.sv
// rtl/pcm_frame_pkg.sv - shared types and defaults for the PCM frame buffer
package pcm_frame_pkg;

   localparam int PCM_NCH   = 4;
   localparam int PCM_W     = 16;
   localparam int PCM_DEPTH = 8;
   localparam int PCM_HDR   = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      DATA = 2'd2
   } pcm_state_t;

   // Width of a channel index; a single-channel build still gets one bit.
   function automatic int chan_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pcm_frame_ram.sv
// rtl/pcm_frame_ram.sv - frame storage, one write port, registered-address read port
module pcm_frame_ram #(
   parameter int DEPTH = 8,
   parameter int DW    = 80
)(
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [DW-1:0]            i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [DW-1:0]            o_rdata
);

   logic [DW-1:0]            r_mem [DEPTH];
   logic [$clog2(DEPTH)-1:0] r_raddr;

   // Write the frame and capture the read address; contents are never reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_raddr <= i_raddr;
   end

   assign o_rdata = r_mem[r_raddr];

endmodule

// File: rtl/pcm_frame_buffer.sv
// rtl/pcm_frame_buffer.sv - multichannel PCM frame FIFO streaming header and sample words
module pcm_frame_buffer
   import pcm_frame_pkg::*;
#(
   parameter int NCH   = PCM_NCH,
   parameter int W     = PCM_W,
   parameter int DEPTH = PCM_DEPTH,
   parameter int HDR   = PCM_HDR
)(
   input  logic                         CLKDIVF0,
   input  logic                         RST,
   input  logic                         in_stb,
   input  logic [NCH*W-1:0]             x_in,
   output logic [W-1:0]                 m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_hdr,
   output logic                         m_last,
   output logic [chan_bits(NCH)-1:0]    m_chan,
   output logic                         overflow,
   input  logic                         clr_ovf,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int CW = chan_bits(NCH);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int DW = NCH*W + W;
   localparam logic [CW-1:0] LAST_CH = CW'(NCH-1);
   localparam logic [LW-1:0] FULL    = LW'(DEPTH);
   localparam pcm_state_t    FIRST   = (HDR != 0) ? HEAD : DATA;

   pcm_state_t      r_state, w_state_nxt;
   logic [CW-1:0]   r_chan, w_chan_nxt;
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
   logic [LW-1:0]   r_level;
   logic [W-1:0]    r_seq;
   logic            r_ovf;
   logic            w_hs, w_pop, w_push, w_drop;
   logic [DW-1:0]   w_rd_word;
   logic [W-1:0]    w_samples [2**CW];

   assign m_valid  = (r_state != IDLE);
   assign w_hs     = m_valid & m_ready;
   assign w_pop    = w_hs & (r_state == DATA) & (r_chan == LAST_CH);
   // A full buffer still takes a frame when the head frame leaves on the same edge.
   assign w_push   = in_stb & ((r_level != FULL) | w_pop);
   assign w_drop   = in_stb & ~w_push;
   // The RAM registers this address, so the next head frame is readable right after a pop.
   assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
   assign overflow = r_ovf;
   assign level    = r_level;

   pcm_frame_ram #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_ram (
      .i_clk   (CLKDIVF0),
      .i_we    (w_push & ~RST),
      .i_waddr (r_wr_ptr),
      .i_wdata ({r_seq, x_in}),
      .i_raddr (w_rd_ptr_nxt),
      .o_rdata (w_rd_word)
   );

   // Unpack the head frame into a channel-indexed table, zero-padded to a power of two.
   for (genvar c = 0; c < 2**CW; c++) begin : g_smp
      if (c < NCH) begin : g_on
         assign w_samples[c] = w_rd_word[c*W +: W];
      end else begin : g_off
         assign w_samples[c] = '0;
      end
   end

   // Output FSM next state: a new frame is only started from stored frames other than the one leaving.
   always_comb begin
      w_state_nxt = r_state;
      w_chan_nxt  = r_chan;
      case (r_state)
         IDLE: if (r_level != '0) w_state_nxt = FIRST;
         HEAD: if (w_hs) w_state_nxt = DATA;
         DATA: begin
            if (w_hs) begin
               if (r_chan == LAST_CH) begin
                  w_chan_nxt  = '0;
                  w_state_nxt = (r_level > LW'(1)) ? FIRST : IDLE;
               end else begin
                  w_chan_nxt  = r_chan + CW'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output FSM state and channel index.
   always_ff @(posedge CLKDIVF0 or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_chan  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_chan  <= w_chan_nxt;
      end
   end

   // FIFO pointers, occupancy, sequence counter and sticky overflow (set wins over clear).
   always_ff @(posedge CLKDIVF0 or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_seq    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         r_rd_ptr <= w_rd_ptr_nxt;
         if (in_stb) r_seq <= r_seq + W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop)       r_ovf <= 1'b1;
         else if (clr_ovf) r_ovf <= 1'b0;
      end
   end

   // Stream word decode; everything is zero outside HEAD and DATA.
   always_comb begin
      m_data = '0;
      m_hdr  = 1'b0;
      m_last = 1'b0;
      m_chan = '0;
      case (r_state)
         HEAD: begin
            m_data = w_rd_word[DW-1 -: W];
            m_hdr  = 1'b1;
         end
         DATA: begin
            m_data = w_samples[r_chan];
            m_last = (r_chan == LAST_CH);
            m_chan = r_chan;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// tb/tb_pcm_frame_buffer.sv - self-checking bench for pcm_frame_buffer
module tb_pcm_frame_buffer;

   localparam int NCH   = 4;
   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int SW    = NCH*W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          RST;
   logic          in_stb, m_ready, clr_ovf;
   logic [SW-1:0] x_in;
   logic [W-1:0]  m_data;
   logic          m_valid, m_hdr, m_last, overflow;
   logic [1:0]    m_chan;
   logic [3:0]    level;

   logic          stb1, rdy1, clr1;
   logic [W-1:0]  x1, data1;
   logic          valid1, hdr1, last1, ovf1;
   logic [0:0]    chan1;
   logic [2:0]    level1;

   pcm_frame_buffer dut (
      .CLKDIVF0 (clk), .RST (RST), .in_stb (in_stb), .x_in (x_in),
      .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready), .m_hdr (m_hdr),
      .m_last (m_last), .m_chan (m_chan), .overflow (overflow), .clr_ovf (clr_ovf),
      .level (level)
   );

   pcm_frame_buffer #(.NCH(1), .W(16), .DEPTH(4), .HDR(0)) dut1 (
      .CLKDIVF0 (clk), .RST (RST), .in_stb (stb1), .x_in (x1),
      .m_data (data1), .m_valid (valid1), .m_ready (rdy1), .m_hdr (hdr1),
      .m_last (last1), .m_chan (chan1), .overflow (ovf1), .clr_ovf (clr1),
      .level (level1)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         hdr;
      logic         last;
      int           chan;
   } word_t;

   word_t         exp_q[$];
   logic [W-1:0]  q1[$];
   int            cnt;
   logic          ovf_m;
   logic [W-1:0]  seq_m;
   int            hs_cnt;
   int            n_checks = 0;
   int            n_errors = 0;
   logic          hold_pend;
   logic [W-1:0]  h_data;
   logic          h_hdr, h_last;
   logic [1:0]    h_chan;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cnt       = 0;
      ovf_m     = 1'b0;
      seq_m     = '0;
      hold_pend = 1'b0;
   endtask

   // A stored frame becomes a header carrying its sequence number followed by its samples.
   task automatic model_push(input logic [SW-1:0] x);
      word_t w;
      w.data = seq_m; w.hdr = 1'b1; w.last = 1'b0; w.chan = 0;
      exp_q.push_back(w);
      for (int c = 0; c < NCH; c++) begin
         w.data = x[c*W +: W];
         w.hdr  = 1'b0;
         w.last = (c == NCH-1);
         w.chan = c;
         exp_q.push_back(w);
      end
   endtask

   function automatic logic [SW-1:0] rnd_x();
      return {$urandom, $urandom};
   endfunction

   // One clock: drive inputs at the falling edge, check, advance the model across the rising edge.
   task automatic cycle(input logic stb, input logic [SW-1:0] x, input logic rdy, input logic clr);
      logic hs, pop, acc;
      in_stb = stb; x_in = x; m_ready = rdy; clr_ovf = clr;
      #1;
      chk("level", level, cnt);
      chk("overflow", overflow, ovf_m);
      if (m_valid) begin
         if (exp_q.size() == 0) begin
            chk("valid_without_frame", m_valid, 0);
         end else begin
            chk("data", m_data, exp_q[0].data);
            chk("hdr",  m_hdr,  exp_q[0].hdr);
            chk("last", m_last, exp_q[0].last);
            chk("chan", m_chan, exp_q[0].chan);
         end
      end
      if (hold_pend) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, h_data);
         chk("hold_hdr", m_hdr, h_hdr);
         chk("hold_last", m_last, h_last);
         chk("hold_chan", m_chan, h_chan);
      end
      hold_pend = m_valid && !rdy;
      h_data = m_data; h_hdr = m_hdr; h_last = m_last; h_chan = m_chan;
      hs  = m_valid && rdy && (exp_q.size() > 0);
      pop = hs && exp_q[0].last;
      if (hs) begin
         void'(exp_q.pop_front());
         hs_cnt++;
      end
      acc = stb && ((cnt < DEPTH) || pop);
      if (acc) begin
         model_push(x);
         cnt++;
      end
      if (stb && !acc) ovf_m = 1'b1;
      else if (clr)    ovf_m = 1'b0;
      if (stb) seq_m = seq_m + 1'b1;
      if (pop) cnt--;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 200 && !(exp_q.size() == 0 && !m_valid); i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("drain_idle", m_valid, 0);
      chk("drain_level", level, 0);
   endtask

   // Asynchronous reset pulse raised mid-cycle; outputs must drop without any clock edge.
   task automatic pulse_reset();
      in_stb = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
      #2 RST = 1'b1;
      #1;
      chk("rst_valid", m_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
      chk("rst_ovf", overflow, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      RST = 1'b0;
   endtask

   initial begin
      logic [3:0] pat;
      logic       done;
      RST = 1'b1; in_stb = 0; m_ready = 0; clr_ovf = 0; x_in = '0;
      stb1 = 0; rdy1 = 0; clr1 = 0; x1 = '0;
      model_reset();
      hs_cnt = 0;
      #1;
      chk("reset_valid", m_valid, 0);
      chk("reset_hdr", m_hdr, 0);
      chk("reset_last", m_last, 0);
      chk("reset_chan", m_chan, 0);
      chk("reset_data", m_data, 0);
      chk("reset_level", level, 0);
      chk("reset_ovf", overflow, 0);
      @(negedge clk);
      RST = 1'b0;

      // Single frame {1,-2,3,-4}
      hs_cnt = 0;
      cycle(1'b1, {16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001}, 1'b1, 1'b0);
      chk("latency_edge_k", m_valid, 0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("latency_edge_k1", m_valid, 1);
      chk("first_is_hdr", m_hdr, 1);
      chk("first_seq", m_data, 0);
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("single_words", hs_cnt, 5);
      chk("single_level", level, 0);

      // Backpressure 1,0,0,1
      hs_cnt = 0;
      pat = 4'b1001;
      cycle(1'b1, rnd_x(), 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) cycle(1'b0, '0, pat[i % 4], 1'b0);
      chk("bp_words", hs_cnt, 5);
      drain();

      // Overflow: 10 strobes into a stalled buffer
      pulse_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, rnd_x(), 1'b0, 1'b0);
      chk("ovf_level_full", level, 8);
      chk("ovf_set", overflow, 1);
      drain();
      cycle(1'b1, rnd_x(), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("after_drop_hdr", m_hdr, 1);
      chk("after_drop_seq", m_data, 10);
      drain();
      chk("ovf_still_set", overflow, 1);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("ovf_cleared", overflow, 0);

      // Full buffer: push coincident with the m_last handshake
      for (int i = 0; i < 8; i++) cycle(1'b1, rnd_x(), 1'b0, 1'b0);
      chk("fpp_level_full", level, 8);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (m_valid && exp_q.size() > 0 && exp_q[0].last) begin
            cycle(1'b1, rnd_x(), 1'b1, 1'b0);
            done = 1'b1;
         end else begin
            cycle(1'b0, '0, 1'b1, 1'b0);
         end
      end
      chk("fpp_reached_last", done, 1);
      chk("fpp_level", level, 8);
      chk("fpp_no_ovf", overflow, 0);
      drain();

      // Reset while streaming channel 2
      cycle(1'b1, rnd_x(), 1'b1, 1'b0);
      for (int i = 0; i < 10 && !(m_valid && !m_hdr && m_chan == 2); i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("mid_chan", m_chan, 2);
      chk("mid_no_last", m_last, 0);
      pulse_reset();
      cycle(1'b1, rnd_x(), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_hdr", m_hdr, 1);
      chk("post_rst_seq", m_data, 0);
      drain();

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 99) < 45, rnd_x(), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
      drain();

      // Single channel, no header, strobe every cycle
      for (int i = 0; i < 40; i++) begin
         stb1 = 1'b1; rdy1 = 1'b1; x1 = W'($urandom);
         #1;
         chk("d1_valid", valid1, (i >= 2));
         chk("d1_level", level1, (i < 2) ? i : 2);
         chk("d1_ovf", ovf1, 0);
         chk("d1_hdr", hdr1, 0);
         if (valid1) begin
            if (q1.size() == 0) begin
               chk("d1_valid_without_frame", valid1, 0);
            end else begin
               chk("d1_last", last1, 1);
               chk("d1_chan", chan1, 0);
               chk("d1_data", data1, q1[0]);
               void'(q1.pop_front());
            end
         end
         q1.push_back(x1);
         @(posedge clk);
         @(negedge clk);
      end
      stb1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
